// File: rtl/touch_pkg.sv
// touch_pkg: shared command bytes, frame geometry and FSM encoding for the touch ADC controller.
package touch_pkg;
    localparam logic [7:0] CMD_X = 8'hD0;
    localparam logic [7:0] CMD_Y = 8'h90;
    localparam int FRAME_LEN = 24;
    localparam int SAMPLE_FIRST = 10;
    localparam int SAMPLE_LAST = 21;
    typedef enum logic [2:0] {IDLE, DEBOUNCE, CONV_X, CONV_Y, PUBLISH, WAIT, RELEASE} state_t;
endpackage

// File: rtl/touch_spi_frame.sv
// touch_spi_frame: one 24-DCLK ADC frame; cs_n leads/trails DCLK by a half-period, command out MSB first,
// 12-bit result captured on DCLK rises 10..21.
module touch_spi_frame
    import touch_pkg::*;
#(
    parameter int CLK_DIV = 16
)(
    input  logic        sys_clk,
    input  logic        iRST_n,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic        adc_dout,
    output logic        adc_cs_n,
    output logic        adc_dclk,
    output logic        adc_din,
    output logic        busy,
    output logic        done,
    output logic [11:0] result
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW = $clog2(2 * FRAME_LEN + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_LAST = PW'(2 * FRAME_LEN);
    localparam logic [PW-1:0] PH_S0 = PW'(2 * SAMPLE_FIRST - 2);
    localparam logic [PW-1:0] PH_S1 = PW'(2 * SAMPLE_LAST - 2);

    logic [DW-1:0] div;
    logic [PW-1:0] ph;
    logic [7:0]    sh;

    assign adc_din = sh[7];

    // ph counts half-periods: 0 is the cs_n lead-in, odd phases have DCLK high, 2*FRAME_LEN is the trail-out
    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            div      <= '0;
            ph       <= '0;
            sh       <= '0;
            result   <= '0;
            adc_cs_n <= 1'b1;
            adc_dclk <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy     <= 1'b1;
                    adc_cs_n <= 1'b0;
                    div      <= '0;
                    ph       <= '0;
                    sh       <= cmd;
                end
            end else if (div != DIV_LAST) begin
                div <= div + 1'b1;
            end else begin
                div <= '0;
                if (ph == PH_LAST) begin
                    busy     <= 1'b0;
                    adc_cs_n <= 1'b1;
                    done     <= 1'b1;
                end else begin
                    ph       <= ph + 1'b1;
                    adc_dclk <= ~ph[0];
                    if (ph[0])
                        sh <= {sh[6:0], 1'b0};
                    else if (ph >= PH_S0 && ph <= PH_S1)
                        result <= {result[10:0], adc_dout};
                end
            end
        end
    end
endmodule

// File: rtl/touch_adc_ctrl.sv
// touch_adc_ctrl: debounced touch-session scanner producing 8-bit X / 10-bit Y coordinates.
// Define TOUCH_AVG4_EN to average four back-to-back conversions per axis.
module touch_adc_ctrl
    import touch_pkg::*;
#(
    parameter int CLK_DIV      = 16,
    parameter int DEBOUNCE_CYC = 4096,
    parameter int SCAN_DLY     = 65536,
    parameter int RELEASE_CYC  = 4096
)(
    input  logic       sys_clk,
    input  logic       iRST_n,
    input  logic       penirq_n,
    input  logic       adc_dout,
    output logic       adc_cs_n,
    output logic       adc_dclk,
    output logic       adc_din,
    output logic [7:0] x_out,
    output logic [9:0] y_out,
    output logic       new_coord,
    output logic       transmit_en
);
    localparam int CM0  = (DEBOUNCE_CYC > RELEASE_CYC) ? DEBOUNCE_CYC : RELEASE_CYC;
    localparam int CMAX = (CM0 > SCAN_DLY) ? CM0 : SCAN_DLY;
    localparam int CW   = $clog2(CMAX + 1);

    state_t        state, nxt;
    logic [1:0]    sync;
    logic          pen, start, busy, done, last, conv_end;
    logic [11:0]   result, conv_val;
    logic [CW-1:0] cnt, cnt_d;
    logic [7:0]    xr;

    assign pen      = sync[1];
    assign conv_end = done && last;

    touch_spi_frame #(.CLK_DIV(CLK_DIV)) u_frame (
        .sys_clk (sys_clk),
        .iRST_n  (iRST_n),
        .start   (start),
        .cmd     (state == CONV_Y ? CMD_Y : CMD_X),
        .adc_dout(adc_dout),
        .adc_cs_n(adc_cs_n),
        .adc_dclk(adc_dclk),
        .adc_din (adc_din),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

`ifdef TOUCH_AVG4_EN
    logic [13:0] acc, sum;
    logic [1:0]  rep;

    assign sum      = acc + 14'(result);
    assign last     = (rep == 2'd3);
    assign conv_val = 12'(sum >> 2);

    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n) begin
            acc <= '0;
            rep <= '0;
        end else if (done) begin
            acc <= last ? '0 : sum;
            rep <= last ? '0 : rep + 1'b1;
        end
    end
`else
    assign last     = 1'b1;
    assign conv_val = result;
`endif

    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    // cnt holds the length of the current qualifying run, so a run that began in the previous state carries over
    always_comb begin
        nxt   = state;
        start = 1'b0;
        cnt_d = (&cnt) ? cnt : cnt + 1'b1;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (!pen) begin
                    nxt   = DEBOUNCE;
                    cnt_d = CW'(1);
                end
            end
            DEBOUNCE: begin
                if (pen)
                    nxt = IDLE;
                else if (cnt >= CW'(DEBOUNCE_CYC - 1)) begin
                    nxt   = CONV_X;
                    cnt_d = '0;
                end
            end
            CONV_X: begin
                cnt_d = '0;
                start = !busy && !done;
                if (conv_end)
                    nxt = CONV_Y;
            end
            CONV_Y: begin
                cnt_d = '0;
                start = !busy && !done;
                if (conv_end)
                    nxt = PUBLISH;
            end
            PUBLISH: begin
                cnt_d = '0;
                nxt   = WAIT;
            end
            WAIT: begin
                if (pen) begin
                    nxt   = RELEASE;
                    cnt_d = CW'(1);
                end else if (cnt >= CW'(SCAN_DLY - 1)) begin
                    nxt   = CONV_X;
                    cnt_d = '0;
                end
            end
            RELEASE: begin
                if (!pen) begin
                    nxt   = WAIT;
                    cnt_d = '0;
                end else if (cnt >= CW'(RELEASE_CYC - 1)) begin
                    nxt   = IDLE;
                    cnt_d = '0;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n) begin
            sync        <= 2'b11;
            cnt         <= '0;
            xr          <= '0;
            x_out       <= '0;
            y_out       <= '0;
            new_coord   <= 1'b0;
            transmit_en <= 1'b0;
        end else begin
            sync        <= {sync[0], penirq_n};
            cnt         <= cnt_d;
            new_coord   <= (state == CONV_Y) && conv_end;
            transmit_en <= !(nxt inside {IDLE, DEBOUNCE});
            if (state == CONV_X && conv_end)
                xr <= 8'(conv_val >> 4);
            if (state == CONV_Y && conv_end) begin
                x_out <= xr;
                y_out <= 10'(conv_val >> 2);
            end
        end
    end
endmodule
